wb_prefetch: RTL and testbench

Instruction prefetcher for the J1 core. It acts as a pipelined Wishbone master that issues sequential read requests to the instruction ROM slave. It buffers returned words with their addresses in a small FIFO and hands them to the CPU with a valid/ready handshake. A redirect input (jump, call, return, interrupt) flushes the buffer and restarts fetching at a new address, discarding any reads still in flight.

---
 rtl/wb_prefetch_if.sv | 21 ++
 rtl/wb_prefetch.sv | 106 ++++++++++
 tb/tb_wb_prefetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_prefetch_if.sv
// Pipelined Wishbone read bus between the instruction prefetcher and the ROM slave.
// clk/rst are carried for the slave side only; the master never looks at them.
interface if_wb #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input logic clk,
  input logic rst
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_i;
  logic          ack;
  logic          stall;

  modport master (output cyc, stb, we, adr, sel, input dat_i, ack, stall);
  modport slave  (input clk, rst, cyc, stb, we, adr, sel, output dat_i, ack, stall);
endinterface

// File: rtl/wb_prefetch.sv
// J1 instruction prefetcher: credit-limited pipelined Wishbone reads into a small {pc, word} FIFO.
// Redirect flushes the FIFO and drops every ack still owed for the abandoned stream.
module wb_prefetch #(
  parameter int            AW       = 13,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [15:0]   insn,
  output logic [AW-1:0] insn_pc,
  output logic          insn_valid,
  input  logic          insn_ready,
  if_wb.master          wb
);
  localparam int            PW     = $clog2(DEPTH);
  localparam int            CW     = PW + 1;
  localparam logic [CW:0]   C_LIM  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_ack_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [AW-1:0] r_pc_mem   [DEPTH];
  logic [15:0]   r_word_mem [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_stb;
  logic          w_accept;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;

  // Every FIFO slot is pre-reserved by a request, so the FIFO can never overflow.
  assign w_credit = {1'b0, r_count} + {1'b0, r_out};
  assign w_stb    = ~rst & ~redirect & (w_credit < C_LIM);
  assign w_accept = w_stb & ~wb.stall;
  // Acks with nothing outstanding belong to a bus cycle cut short by reset.
  assign w_ack    = wb.ack & (r_out != '0);
  assign w_push   = w_ack & (r_disc == '0) & ~redirect;
  assign w_pop    = insn_valid & insn_ready & ~redirect;

  assign wb.stb = w_stb;
  assign wb.cyc = w_stb | (r_out != '0);
  assign wb.adr = r_fetch_pc;
  assign wb.we  = 1'b0;
  assign wb.sel = '1;

  assign insn_valid = (r_count != '0);
  assign insn       = r_word_mem[r_rd];
  assign insn_pc    = r_pc_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_ack_pc   <= RESET_PC;
      r_out      <= '0;
      r_disc     <= '0;
    end else begin
      r_out <= r_out + CW'(w_accept) - CW'(w_ack);
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_ack_pc   <= redirect_pc;
        r_disc     <= r_out - CW'(w_ack);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + AW'(1);
        if (w_push) r_ack_pc <= r_ack_pc + AW'(1);
        if (w_ack && (r_disc != '0)) r_disc <= r_disc - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_word_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr]   <= r_ack_pc;
        r_word_mem[r_wr] <= wb.dat_i;
        r_wr             <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == C_FULL)));

endmodule

// File: tb/tb_wb_prefetch.sv
// Directed bench for wb_prefetch: per-cycle vector tables plus a hand-written mid-burst reset.
module tb_wb_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [12:0] redirect_pc;
  logic [15:0] insn;
  logic [12:0] insn_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic        stall;
  logic        sl_clr;
  int          lat;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  if_wb #(.AW(13), .DW(16)) wb_bus (.clk(clk), .rst(rst));

  wb_prefetch #(.AW(13), .DEPTH(4), .RESET_PC(13'h0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .wb(wb_bus)
  );

  function automatic logic [15:0] rom(input logic [12:0] a);
    return {3'b000, a} ^ 16'hA5A5;
  endfunction

  // ROM slave: registered ack 1 or 2 cycles after acceptance; survives DUT reset.
  bit          v1, v2;
  logic [12:0] a1, a2;
  always @(posedge wb_bus.clk) begin
    if (wb_bus.rst && sl_clr) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= wb_bus.stb & ~wb_bus.stall;
      a1 <= wb_bus.adr;
      v2 <= v1;
      a2 <= a1;
    end
  end
  assign wb_bus.ack   = (lat == 1) ? v1 : v2;
  assign wb_bus.dat_i = rom((lat == 1) ? a1 : a2);
  assign wb_bus.stall = stall;

  typedef struct packed {
    logic        ready;
    logic        stall;
    logic        redir;
    logic [12:0] rpc;
    logic        e_cyc;
    logic        e_stb;
    logic [12:0] e_adr;
    logic        e_valid;
    logic [12:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rdy, input bit stl, input bit rd, input int rpc,
                              input bit ec, input bit es, input int ea, input bit ev, input int ep);
    vec_t v;
    v.ready = rdy; v.stall = stl; v.redir = rd; v.rpc = rpc[12:0];
    v.e_cyc = ec; v.e_stb = es; v.e_adr = ea[12:0]; v.e_valid = ev; v.e_pc = ep[12:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Leaves the bench mid-cycle 0 with reset just released.
  task automatic start(input int l, input logic rdy);
    rst = 1'b1; sl_clr = 1'b1; redirect = 1'b0; redirect_pc = '0;
    insn_ready = rdy; stall = 1'b0; lat = l;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset cyc", wb_bus.cyc, 0);
    chk("reset stb", wb_bus.stb, 0);
    chk("reset adr", wb_bus.adr, 0);
    chk("reset insn_valid", insn_valid, 0);
    chk("reset insn", insn, 0);
    chk("reset insn_pc", insn_pc, 0);
    rst = 1'b0; sl_clr = 1'b0;
  endtask

  task automatic run_tbl(input string tag, input int l);
    start(l, tbl[0].ready);
    for (int k = 0; k < tbl.size(); k++) begin
      insn_ready = tbl[k].ready; stall = tbl[k].stall;
      redirect = tbl[k].redir; redirect_pc = tbl[k].rpc;
      #1;
      chk($sformatf("%s c%0d cyc", tag, k), wb_bus.cyc, tbl[k].e_cyc);
      chk($sformatf("%s c%0d stb", tag, k), wb_bus.stb, tbl[k].e_stb);
      if (tbl[k].e_stb) chk($sformatf("%s c%0d adr", tag, k), wb_bus.adr, tbl[k].e_adr);
      chk($sformatf("%s c%0d insn_valid", tag, k), insn_valid, tbl[k].e_valid);
      if (tbl[k].e_valid) begin
        chk($sformatf("%s c%0d insn_pc", tag, k), insn_pc, tbl[k].e_pc);
        chk($sformatf("%s c%0d insn", tag, k), insn, rom(tbl[k].e_pc));
      end
      @(negedge clk);
    end
    redirect = 1'b0; stall = 1'b0;
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Stream, redirect to 0x0100, then redirect across the 13-bit wrap.
    tbl.push_back(mk(1,0,0,0,      1,1,'h0000,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0001,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0002,1,'h0000));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0003,1,'h0001));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0004,1,'h0002));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0005,1,'h0003));
    tbl.push_back(mk(1,0,1,'h0100, 1,0,0,     1,'h0004));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0100,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0101,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0102,1,'h0100));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0103,1,'h0101));
    tbl.push_back(mk(1,0,1,'h1FFE, 1,0,0,     1,'h0102));
    tbl.push_back(mk(1,0,0,0,      1,1,'h1FFE,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h1FFF,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0000,1,'h1FFE));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0001,1,'h1FFF));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0002,1,'h0000));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0003,1,'h0001));
    run_tbl("stream", 1);
    chk("bus we", wb_bus.we, 0);
    chk("bus sel", wb_bus.sel, 2'b11);

    // Backpressure: four requests fill the credit, release resumes at adr 4.
    tbl.push_back(mk(0,0,0,0, 1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,2,1,0));
    tbl.push_back(mk(0,0,0,0, 1,1,3,1,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,1,4,1,1));
    tbl.push_back(mk(1,0,0,0, 1,1,5,1,2));
    tbl.push_back(mk(1,0,0,0, 1,1,6,1,3));
    tbl.push_back(mk(1,0,0,0, 1,1,7,1,4));
    tbl.push_back(mk(1,0,0,0, 1,1,8,1,5));
    run_tbl("backpressure", 1);

    // Two-cycle slave: redirect with two reads in flight, both stale acks dropped.
    tbl.push_back(mk(1,0,0,0,      1,1,'h0000,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0001,0,0));
    tbl.push_back(mk(1,0,1,'h0100, 1,0,0,     0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0100,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0101,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0102,0,0));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0103,1,'h0100));
    tbl.push_back(mk(1,0,0,0,      1,1,'h0104,1,'h0101));
    run_tbl("redirect_inflight", 2);

    // Slave stalls the request for adr 5 for three cycles.
    tbl.push_back(mk(1,0,0,0, 1,1,0,0,0));
    tbl.push_back(mk(1,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,1,2,1,0));
    tbl.push_back(mk(1,0,0,0, 1,1,3,1,1));
    tbl.push_back(mk(1,0,0,0, 1,1,4,1,2));
    tbl.push_back(mk(1,1,0,0, 1,1,5,1,3));
    tbl.push_back(mk(1,1,0,0, 1,1,5,1,4));
    tbl.push_back(mk(1,1,0,0, 1,1,5,0,0));
    tbl.push_back(mk(1,0,0,0, 1,1,5,0,0));
    tbl.push_back(mk(1,0,0,0, 1,1,6,0,0));
    tbl.push_back(mk(1,0,0,0, 1,1,7,1,5));
    tbl.push_back(mk(1,0,0,0, 1,1,8,1,6));
    run_tbl("stall", 1);

    // Reset pulse in cycle 3 while the ack for adr 2 is on the bus.
    start(1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("midrst pre insn_valid", insn_valid, 1);
    chk("midrst pre insn_pc", insn_pc, 1);
    rst = 1'b1;
    #1;
    chk("midrst insn_valid", insn_valid, 0);
    chk("midrst insn", insn, 0);
    chk("midrst insn_pc", insn_pc, 0);
    chk("midrst stb", wb_bus.stb, 0);
    chk("midrst cyc", wb_bus.cyc, 0);
    rst = 1'b0;
    #1;
    chk("midrst restart stb", wb_bus.stb, 1);
    chk("midrst restart adr", wb_bus.adr, 0);
    @(negedge clk); #1;
    chk("midrst late ack insn_valid", insn_valid, 0);
    chk("midrst c4 stb", wb_bus.stb, 1);
    chk("midrst c4 adr", wb_bus.adr, 1);
    @(negedge clk); #1;
    chk("midrst c5 insn_valid", insn_valid, 1);
    chk("midrst c5 insn_pc", insn_pc, 0);
    chk("midrst c5 insn", insn, 16'hA5A5);
    @(negedge clk); #1;
    chk("midrst c6 insn_pc", insn_pc, 1);
    chk("midrst c6 insn", insn, 16'hA5A4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
